// File: rtl/sobel_linebuf.sv
// Raster-to-column line buffer for the Sobel stage: emits an M_DEPTH-tall vector
// (current pixel plus the same column of earlier lines) one cycle after each input.
module sobel_linebuf #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 3,
    parameter int LINE_W     = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COLORDEPTH-1:0]                 px_i,
    input  logic                                  dv_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [M_DEPTH-1:0][COLORDEPTH-1:0]    vect_o,
    output logic                                  dv_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic                                  rows_valid_o,
    output logic                                  overflow_o
);

    localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int LC_W   = $clog2(M_DEPTH);
    localparam int NMEM   = M_DEPTH - 1;
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(LINE_W - 1);
    localparam logic [LC_W-1:0]   LC_MAX  = LC_W'(M_DEPTH - 1);

    logic [ADDR_W-1:0]                 col;
    logic [ADDR_W-1:0]                 addr_q;
    logic                              col_full;
    logic                              dv_prev;
    logic                              vs_prev;
    logic                              wr_q;
    logic [LC_W-1:0]                   line_cnt;
    logic [LC_W-1:0]                   lc_eff;
    logic                              vs_rise;
    logic                              dv_fall;
    logic [COLORDEPTH-1:0]             mem [NMEM][LINE_W];
    logic [NMEM-1:0][COLORDEPTH-1:0]   rd_q;
    logic [NMEM-1:0][COLORDEPTH-1:0]   rd_next;
    logic [COLORDEPTH-1:0]             px_q;
    logic [M_DEPTH-1:1]                mask_q;

    assign vs_rise = vs_i & ~vs_prev;
    assign dv_fall = ~dv_i & dv_prev;
    // A pixel landing on the frame-start edge already belongs to line 0.
    assign lc_eff  = vs_rise ? '0 : line_cnt;

    // Cascade writes lag one cycle; only a saturated column can re-read that address.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < NMEM; k++) begin
            rd_next[k] = mem[k][col];
        end
        if (wr_q && (addr_q == col)) begin
            for (int k = 1; k < NMEM; k++) begin
                rd_next[k] = rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= col;
        if (dv_i) begin
            mem[0][col] <= px_i;
            rd_q        <= rd_next;
        end
        if (wr_q) begin
            for (int k = 1; k < NMEM; k++) begin
                mem[k][addr_q] <= rd_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_o         <= 1'b0;
            hs_o         <= 1'b0;
            vs_o         <= 1'b0;
            dv_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            wr_q         <= 1'b0;
            rows_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
            px_q         <= '0;
            mask_q       <= '0;
            col          <= '0;
            col_full     <= 1'b0;
            line_cnt     <= '0;
        end else begin
            dv_o         <= dv_i;
            hs_o         <= hs_i;
            vs_o         <= vs_i;
            dv_prev      <= dv_i;
            vs_prev      <= vs_i;
            wr_q         <= dv_i;
            rows_valid_o <= (lc_eff == LC_MAX);

            if (dv_i) begin
                px_q <= px_i;
                for (int k = 1; k < M_DEPTH; k++) begin
                    mask_q[k] <= (int'(lc_eff) >= k);
                end
                col      <= (col == COL_MAX) ? col : col + 1'b1;
                col_full <= col_full | (col == COL_MAX);
                if ((col == COL_MAX) && col_full) begin
                    overflow_o <= 1'b1;
                end
            end else begin
                col      <= '0;
                col_full <= 1'b0;
            end

            if (vs_rise) begin
                line_cnt <= '0;
            end else if (dv_fall && (line_cnt != LC_MAX)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        vect_o    = '0;
        vect_o[0] = px_q;
        for (int k = 1; k < M_DEPTH; k++) begin
            if (mask_q[k]) begin
                vect_o[k] = rd_q[k-1];
            end
        end
    end

endmodule

// File: tb/tb_sobel_linebuf.sv
// Bench for sobel_linebuf (M_DEPTH=3, LINE_W=8): directed window/masking/overflow
// cases plus random raster traffic, checked against a per-pixel column-history model.
module tb_sobel_linebuf;

    localparam int CD = 8;
    localparam int MD = 3;
    localparam int LW = 8;

    logic                    clk;
    logic                    rst;
    logic [CD-1:0]           px_i;
    logic                    dv_i;
    logic                    hs_i;
    logic                    vs_i;
    logic [MD-1:0][CD-1:0]   vect_o;
    logic                    dv_o;
    logic                    hs_o;
    logic                    vs_o;
    logic                    rows_valid_o;
    logic                    overflow_o;

    sobel_linebuf #(.COLORDEPTH(CD), .M_DEPTH(MD), .LINE_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .px_i         (px_i),
        .dv_i         (dv_i),
        .hs_i         (hs_i),
        .vs_i         (vs_i),
        .vect_o       (vect_o),
        .dv_o         (dv_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .rows_valid_o (rows_valid_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // column history: hist[0][c] = last line's pixel at c, hist[1][c] = the one before
    logic [7:0]  hist [2][LW];
    int          m_cnt = 0;
    int          m_lc  = 0;
    bit          m_ovf = 0;
    bit          m_pdv = 0;
    bit          m_pvs = 0;
    logic [23:0] e_vect = '0;
    bit          e_dv = 0, e_hs = 0, e_vs = 0, e_rv = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Apply one cycle of input at a negedge, predict, then check at the next negedge.
    task automatic cyc(input logic [7:0] px, input bit dv, input bit hs, input bit vs);
        int  eff;
        int  addr;
        bit  vrise;
        px_i = px; dv_i = dv; hs_i = hs; vs_i = vs;
        vrise = vs && !m_pvs;
        eff   = vrise ? 0 : m_lc;
        e_dv = dv; e_hs = hs; e_vs = vs;
        e_rv = (eff == MD - 1);
        if (dv) begin
            addr = (m_cnt < LW) ? m_cnt : LW - 1;
            if (m_cnt >= LW) m_ovf = 1;
            e_vect[7:0]   = px;
            e_vect[15:8]  = (eff >= 1) ? hist[0][addr] : 8'h00;
            e_vect[23:16] = (eff >= 2) ? hist[1][addr] : 8'h00;
            hist[1][addr] = hist[0][addr];
            hist[0][addr] = px;
            m_cnt++;
        end else begin
            m_cnt = 0;
        end
        if (vrise) m_lc = 0;
        else if (!dv && m_pdv && m_lc < MD - 1) m_lc++;
        m_pdv = dv;
        m_pvs = vs;
        @(negedge clk);
        check_val("vect", vect_o, e_vect);
        check_val("dv_o", dv_o, e_dv);
        check_val("hs_o", hs_o, e_hs);
        check_val("vs_o", vs_o, e_vs);
        check_val("rows_valid", rows_valid_o, e_rv);
        check_val("overflow", overflow_o, m_ovf);
    endtask

    task automatic send_line(input int len, input int gap);
        for (int c = 0; c < len; c++) cyc(8'($urandom), 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < gap; g++) cyc(8'h00, 1'b0, (g == 0) && ($urandom_range(0, 1) == 1), 1'b0);
    endtask

    task automatic do_reset();
        cyc(8'h00, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("rst_vect", vect_o, 0);
        check_val("rst_dv", dv_o, 0);
        check_val("rst_hs", hs_o, 0);
        check_val("rst_vs", vs_o, 0);
        check_val("rst_rv", rows_valid_o, 0);
        check_val("rst_ovf", overflow_o, 0);
        m_cnt = 0; m_lc = 0; m_ovf = 0; m_pdv = 0; m_pvs = 0;
        e_vect = '0; e_dv = 0; e_hs = 0; e_vs = 0; e_rv = 0;
        px_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; px_i = '0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < LW; c++) hist[k][c] = 8'h00;
        #2 rst = 1'b1;
        #1;
        check_val("init_vect", vect_o, 0);
        check_val("init_ovf", overflow_o, 0);
        check_val("init_rv", rows_valid_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // full-width frame so every line-memory column holds defined data
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) send_line(LW, 1);

        // basic window: line L column c carries 16*L + c
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 4; c++) begin
                cyc(8'(16 * l + c), 1'b1, 1'b0, 1'b0);
                if (l == 0 && c == 0) begin
                    check_val("l0_vect", vect_o, 24'h000000);
                    check_val("l0_rv", rows_valid_o, 0);
                end
                if (l == 1 && c == 2) begin
                    check_val("l1_vect", vect_o, 24'h000212);
                    check_val("l1_rv", rows_valid_o, 0);
                end
                if (l == 2 && c == 1) begin
                    check_val("l2_vect", vect_o, 24'h011121);
                    check_val("l2_rv", rows_valid_o, 1);
                    check_val("l2_dv", dv_o, 1);
                end
            end
            cyc(8'h00, 1'b0, 1'b1, 1'b0);
            cyc(8'h00, 1'b0, 1'b0, 1'b0);
        end

        // new frame after a vs pulse
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            cyc(8'hAA, 1'b1, 1'b0, 1'b0);
            check_val("nf_vect", vect_o, 24'h0000AA);
            check_val("nf_rv", rows_valid_o, 0);
        end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        send_line(5, 1);

        // vs rising together with the first pixel
        cyc(8'h55, 1'b1, 1'b0, 1'b1);
        check_val("vsdv_vect", vect_o, 24'h000055);
        for (int c = 1; c < 6; c++) cyc(8'($urandom), 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);

        // overflow: 10-pixel line, then an 8-pixel line reading column 7
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cyc(8'(8'h80 + c), 1'b1, 1'b0, 1'b0);
            if (c == 7) check_val("ovf_pre", overflow_o, 0);
            if (c == 8) check_val("ovf_9th", overflow_o, 1);
        end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) begin
            cyc(8'(8'h40 + c), 1'b1, 1'b0, 1'b0);
            if (c == 7) check_val("ovf_col7", vect_o[1], 8'h89);
        end
        cyc(8'h00, 1'b0, 1'b0, 1'b0);
        check_val("ovf_sticky", overflow_o, 1);

        // random raster with sync pulses, 1-3 cycle gaps and a mid-frame reset
        for (int l = 0; l < 60; l++) begin
            int len;
            int gap;
            int vsel;
            len  = $urandom_range(1, 10);
            gap  = $urandom_range(1, 3);
            vsel = $urandom_range(0, 7);
            if (l == 30) begin
                for (int c = 0; c < 3; c++) cyc(8'($urandom), 1'b1, 1'b0, 1'b0);
                do_reset();
            end
            if (vsel == 0) begin
                cyc(8'h00, 1'b0, 1'b0, 1'b1);
            end else if (vsel == 1) begin
                cyc(8'($urandom), 1'b1, 1'b0, 1'b1);
                len = len - 1;
            end
            send_line(len, gap);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
